// File: rtl/accum_op_unit.sv
// Operation stage behind the operand accumulator: capture, check, execute, report.
// Define OPU_MUL_EN to build the iterative shift-add multiplier for opcode 6.
module accum_op_unit #(
  parameter int W   = 8,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic [W-1:0]   r0,
  input  logic [W-1:0]   r1,
  input  logic [W-1:0]   r2,
  input  logic           r0_valid,
  input  logic           r1_valid,
  input  logic           r2_valid,
  output logic           busy,
  output logic           done,
  output logic           acc_clr,
  output logic [W-1:0]   result,
  output logic           carry,
  output logic           err
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_AND  = OPW'(2);
  localparam logic [OPW-1:0] OP_OR   = OPW'(3);
  localparam logic [OPW-1:0] OP_XOR  = OPW'(4);
  localparam logic [OPW-1:0] OP_ADD3 = OPW'(5);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(6);
  localparam logic [OPW-1:0] OP_SEL  = OPW'(7);

`ifdef OPU_MUL_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2,
    S_MUL  = 2'd3
  } state_t;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t         r_state;
  logic [OPW-1:0] r_op;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_c;
  logic           r_va;
  logic           r_vb;
  logic           r_vc;
  logic [W-1:0]   r_res;
  logic           r_cy;
  logic           r_er;

  logic           w_need3;
  logic           w_ok;
  logic           w_bad;
  logic [W-1:0]   w_res;
  logic           w_cy;
  logic [W:0]     w_sum2;
  logic [W:0]     w_diff;
  logic [W+1:0]   w_sum3;

`ifdef OPU_MUL_EN
  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplr;
  logic [2*W-1:0] r_prod;
  logic [CW-1:0]  r_cnt;
  logic           w_mul;
  logic [2*W-1:0] w_prod_nxt;

  assign w_prod_nxt = r_prod + (r_mplr[0] ? r_mcand : '0);
`endif

  assign busy    = (r_state != S_IDLE);
  assign w_need3 = (r_op == OP_ADD3) || (r_op == OP_SEL);
  assign w_ok    = r_va & r_vb & (~w_need3 | r_vc);
  assign w_sum2  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
  assign w_sum3  = {2'b0, r_a} + {2'b0, r_b} + {2'b0, r_c};

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    w_bad = 1'b0;
`ifdef OPU_MUL_EN
    w_mul = 1'b0;
`endif
    unique case (1'b1)
      (r_op == OP_ADD):  {w_cy, w_res} = w_sum2;
      (r_op == OP_SUB):  {w_cy, w_res} = w_diff;
      (r_op == OP_AND):  w_res = r_a & r_b;
      (r_op == OP_OR):   w_res = r_a | r_b;
      (r_op == OP_XOR):  w_res = r_a ^ r_b;
      (r_op == OP_ADD3): begin
        w_res = w_sum3[W-1:0];
        w_cy  = |w_sum3[W+1:W];
      end
`ifdef OPU_MUL_EN
      (r_op == OP_MUL):  w_mul = 1'b1;
`else
      (r_op == OP_MUL):  w_bad = 1'b1;
`endif
      (r_op == OP_SEL):  w_res = (|r_c) ? r_a : r_b;
      default:           w_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_va    <= 1'b0;
      r_vb    <= 1'b0;
      r_vc    <= 1'b0;
      r_res   <= '0;
      r_cy    <= 1'b0;
      r_er    <= 1'b0;
      done    <= 1'b0;
      acc_clr <= 1'b0;
      result  <= '0;
      carry   <= 1'b0;
      err     <= 1'b0;
`ifdef OPU_MUL_EN
      r_mcand <= '0;
      r_mplr  <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
`endif
    end else begin
      done    <= 1'b0;
      acc_clr <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= opcode;
            r_a     <= r0;
            r_b     <= r1;
            r_c     <= r2;
            r_va    <= r0_valid;
            r_vb    <= r1_valid;
            r_vc    <= r2_valid;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (!w_ok || w_bad) begin
            r_res   <= '0;
            r_cy    <= 1'b0;
            r_er    <= 1'b1;
            r_state <= S_DONE;
`ifdef OPU_MUL_EN
          end else if (w_mul) begin
            r_mcand <= {{W{1'b0}}, r_a};
            r_mplr  <= r_b;
            r_prod  <= '0;
            r_cnt   <= '0;
            r_state <= S_MUL;
`endif
          end else begin
            r_res   <= w_res;
            r_cy    <= w_cy;
            r_er    <= 1'b0;
            r_state <= S_DONE;
          end
        end
`ifdef OPU_MUL_EN
        S_MUL: begin
          r_prod  <= w_prod_nxt;
          r_mcand <= r_mcand << 1;
          r_mplr  <= r_mplr >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(W-1)) begin
            r_res   <= w_prod_nxt[W-1:0];
            r_cy    <= |w_prod_nxt[2*W-1:W];
            r_er    <= 1'b0;
            r_state <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          // Outputs publish together with the done pulse.
          done    <= 1'b1;
          acc_clr <= 1'b1;
          result  <= r_res;
          carry   <= r_cy;
          err     <= r_er;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_op_unit.sv
// Scoreboard bench for accum_op_unit: expected results queued at issue,
// popped by a negedge monitor when done pulses.
module tb_accum_op_unit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic [7:0] r0, r1, r2;
  logic       r0_valid, r1_valid, r2_valid;
  logic       busy, done, acc_clr, carry, err;
  logic [7:0] result;

  typedef struct {
    logic [7:0] res;
    logic       cy;
    logic       er;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [7:0] p_res = '0;
  logic       p_cy = 1'b0;
  logic       p_er = 1'b0;

  accum_op_unit #(.W(8), .OPW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .r0(r0), .r1(r1), .r2(r2),
    .r0_valid(r0_valid), .r1_valid(r1_valid), .r2_valid(r2_valid),
    .busy(busy), .done(done), .acc_clr(acc_clr),
    .result(result), .carry(carry), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checks++;
      if (done) begin
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d res=%0d", cyc, result);
        end else begin
          e = sb.pop_front();
          if ({result, carry, err, acc_clr} !== {e.res, e.cy, e.er, 1'b1} ||
              cyc != e.cyc) begin
            errors++;
            $display("FAIL done_out got res=%0d cy=%b er=%b clr=%b cyc=%0d want res=%0d cy=%b er=%b clr=1 cyc=%0d",
                     result, carry, err, acc_clr, cyc, e.res, e.cy, e.er, e.cyc);
          end
        end
      end else if (acc_clr !== 1'b0 || result !== p_res ||
                   carry !== p_cy || err !== p_er) begin
        errors++;
        $display("FAIL hold got clr=%b res=%0d cy=%b er=%b want clr=0 res=%0d cy=%b er=%b",
                 acc_clr, result, carry, err, p_res, p_cy, p_er);
      end
    end
    p_res = result;
    p_cy  = carry;
    p_er  = err;
  end

  task automatic drive(input logic [2:0] op, input logic [7:0] a, b, c,
                       input logic va, vb, vc);
    exp_t e;
    int ia, ib, ic, s, lat;
    bit ok;
    ia = a; ib = b; ic = c;
    lat = 2;
    e.res = '0; e.cy = 1'b0; e.er = 1'b0;
    ok = va && vb && (((op == 3'd5) || (op == 3'd7)) ? vc : 1'b1);
    if (!ok) e.er = 1'b1;
    else begin
      case (op)
        3'd0: begin s = ia + ib; e.res = 8'(s); e.cy = (s > 255); end
        3'd1: begin e.res = 8'(ia - ib); e.cy = (ia < ib); end
        3'd2: e.res = a & b;
        3'd3: e.res = a | b;
        3'd4: e.res = a ^ b;
        3'd5: begin s = ia + ib + ic; e.res = 8'(s); e.cy = (s > 255); end
`ifdef OPU_MUL_EN
        3'd6: begin s = ia * ib; e.res = 8'(s); e.cy = (s > 255); lat = 10; end
`else
        3'd6: e.er = 1'b1;
`endif
        default: e.res = (ic != 0) ? a : b;
      endcase
    end
    e.cyc = cyc + 1 + lat;
    opcode = op; r0 = a; r1 = b; r2 = c;
    r0_valid = va; r1_valid = vb; r2_valid = vc;
    start = 1'b1;
    sb.push_back(e);
  endtask

  task automatic scramble();
    start    = 1'b0;
    opcode   = 3'($urandom);
    r0       = 8'($urandom);
    r1       = 8'($urandom);
    r2       = 8'($urandom);
    r0_valid = 1'($urandom);
    r1_valid = 1'($urandom);
    r2_valid = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
    checks++;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL timeout pending=%0d want 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] a, b, c,
                        input logic va, vb, vc);
    @(negedge clk);
    drive(op, a, b, c, va, vb, vc);
    @(negedge clk);
    scramble();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_exec got %b want 1", busy);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; start = 1'b0; opcode = '0;
    r0 = '0; r1 = '0; r2 = '0;
    r0_valid = 1'b0; r1_valid = 1'b0; r2_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks += 6;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    if (acc_clr !== 1'b0) begin errors++; $display("FAIL rst_clr got %b want 0", acc_clr); end
    if (result !== 8'd0) begin errors++; $display("FAIL rst_res got %0d want 0", result); end
    if (carry !== 1'b0) begin errors++; $display("FAIL rst_cy got %b want 0", carry); end
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_arith();
    run_op(3'd0, 8'd200, 8'd100, 8'd0, 1, 1, 0);
    run_op(3'd1, 8'd5, 8'd7, 8'd0, 1, 1, 0);
    run_op(3'd1, 8'd7, 8'd5, 8'd0, 1, 1, 0);
    run_op(3'd5, 8'd100, 8'd100, 8'd100, 1, 1, 1);
    run_op(3'd2, 8'hF0, 8'h3C, 8'd0, 1, 1, 0);
    run_op(3'd3, 8'hF0, 8'h0C, 8'd0, 1, 1, 0);
    run_op(3'd4, 8'hFF, 8'h0F, 8'd0, 1, 1, 0);
    run_op(3'd7, 8'd11, 8'd22, 8'd1, 1, 1, 1);
    run_op(3'd7, 8'd11, 8'd22, 8'd0, 1, 1, 1);
  endtask

  task automatic test_mul();
    run_op(3'd6, 8'd15, 8'd17, 8'd0, 1, 1, 0);
    run_op(3'd6, 8'd16, 8'd16, 8'd0, 1, 1, 0);
    run_op(3'd6, 8'd255, 8'd255, 8'd0, 1, 1, 0);
  endtask

  task automatic test_missing();
    run_op(3'd0, 8'd1, 8'd2, 8'd0, 1, 0, 1);
    run_op(3'd7, 8'd1, 8'd2, 8'd3, 1, 1, 0);
    run_op(3'd5, 8'd1, 8'd2, 8'd3, 1, 1, 0);
    run_op(3'd6, 8'd3, 8'd4, 8'd0, 0, 1, 1);
  endtask

  task automatic test_start_held();
    int t;
    @(negedge clk);
    drive(3'd6, 8'd9, 8'd9, 8'd0, 1, 1, 0);
    t = sb[sb.size()-1].cyc;
    for (int i = 0; i < 40 && cyc < t; i++) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL held_start got pending=%0d busy=%b want 0 0", sb.size(), busy);
      sb.delete();
    end
  endtask

  task automatic test_back_to_back();
    int t;
    @(negedge clk);
    drive(3'd0, 8'd200, 8'd100, 8'd0, 1, 1, 0);
    t = sb[sb.size()-1].cyc;
    for (int i = 0; i < 40 && cyc < t; i++) @(negedge clk);
    drive(3'd1, 8'd5, 8'd7, 8'd0, 1, 1, 0);
    t = sb[sb.size()-1].cyc;
    for (int i = 0; i < 40 && cyc < t; i++) @(negedge clk);
    drive(3'd6, 8'd15, 8'd17, 8'd0, 1, 1, 0);
    @(negedge clk);
    scramble();
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int n;
`ifdef OPU_MUL_EN
    n = 4;
`else
    n = 1;
`endif
    run_op(3'd0, 8'd200, 8'd100, 8'd0, 1, 1, 0);
    @(negedge clk);
    drive(3'd6, 8'd15, 8'd17, 8'd0, 1, 1, 0);
    @(negedge clk);
    scramble();
    repeat (n) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    if ({result, carry, err} !== 10'd0) begin
      errors++;
      $display("FAIL mid_outs got res=%0d cy=%b er=%b want 0 0 0", result, carry, err);
    end
    if ({done, acc_clr} !== 2'b00) begin
      errors++;
      $display("FAIL mid_pulse got done=%b clr=%b want 0 0", done, acc_clr);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run_op(3'd0, 8'd1, 8'd2, 8'd0, 1, 1, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++)
      run_op(3'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 2)),
             1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 9) != 0));
  endtask

  initial begin
    test_reset();
    test_arith();
    test_mul();
    test_missing();
    test_start_held();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
